// File: rtl/vblank_update_scheduler.sv
// Round-robin scheduler that grants game-state updates only inside vertical blanking.
// Define VSCHED_FIXED_PRI_EN to grant requester 0 first in every window.
module vblank_update_scheduler #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned Y_START     = 34,
  parameter int unsigned V_ACT       = 480,
  parameter int unsigned GUARD_LINES = 2,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [9:0]         iV_Cont,
  input  logic [9:0]         iH_Cont,
  input  logic [NUM_REQ-1:0] iReq,
  input  logic [NUM_REQ-1:0] iDone,
  output logic [NUM_REQ-1:0] oGrant,
  output logic               oBusy,
  output logic               oFrame_Tick,
  output logic [NUM_REQ-1:0] oServed,
  output logic               oTimeout_Err,
  output logic               oOverrun_Err,
  output logic [15:0]        oFrame_Cnt
);

  localparam int unsigned PW         = $clog2(NUM_REQ);
  localparam logic [9:0]  OPEN_LINE  = 10'(Y_START + V_ACT);
  localparam logic [9:0]  CLOSE_LINE = 10'(Y_START - GUARD_LINES);
  localparam logic [9:0]  TMO_LAST   = 10'(TIMEOUT - 1);

`ifdef VSCHED_FIXED_PRI_EN
  localparam bit FIXED_PRI = 1'b1;
`else
  localparam bit FIXED_PRI = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StArb, StGrant, StDone} state_e;

  state_e             state_q, state_d;
  logic               open_q, open_d;
  logic               close;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      idx_q, idx_d;
  logic [NUM_REQ-1:0] served_q, served_d;
  logic [NUM_REQ-1:0] cand, idx_oh;
  logic [9:0]         tmo_q, tmo_d;
  logic               tick_q, tick_d;
  logic               terr_q, terr_d;
  logic               oerr_q, oerr_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               pick_found;
  logic [PW-1:0]      pick_idx;
  logic               done_k, tmo_hit, moves_ptr;

  // Returns {found, index} of the first candidate at or after p, wrapping.
  function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] c,
                                          input logic [PW-1:0] p);
    logic [PW:0] res;
    logic [PW:0] pos;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pos = {1'b0, p} + (PW+1)'(i);
      if (pos >= (PW+1)'(NUM_REQ)) pos = pos - (PW+1)'(NUM_REQ);
      if (c[pos[PW-1:0]]) res = {1'b1, pos[PW-1:0]};
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] i);
    return (i == PW'(NUM_REQ - 1)) ? '0 : i + PW'(1);
  endfunction

  always_comb begin
    open_d = (iV_Cont == OPEN_LINE) && (iH_Cont == 10'd0);
    close  = (iV_Cont == CLOSE_LINE) && (iH_Cont == 10'd0);
    cand   = iReq & ~served_q;
    {pick_found, pick_idx} = rr_pick(cand, ptr_q);
    if (FIXED_PRI && cand[0]) begin
      pick_found = 1'b1;
      pick_idx   = '0;
    end
    idx_oh         = '0;
    idx_oh[idx_q]  = 1'b1;
    done_k         = |(iDone & idx_oh);
    tmo_hit        = (tmo_q == TMO_LAST);
    // A fixed-priority requester 0 is served outside the rotation.
    moves_ptr      = !(FIXED_PRI && (idx_q == '0));

    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    served_d    = served_q;
    tmo_d       = tmo_q;
    tick_d      = 1'b0;
    terr_d      = terr_q;
    oerr_d      = oerr_q;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (open_q) begin
          state_d     = StArb;
          tick_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          served_d    = '0;
        end
      end
      StArb: begin
        if (close) begin
          state_d = StDone;
          oerr_d  = oerr_q | (|cand);
        end else if (!pick_found) begin
          state_d = StDone;
        end else begin
          state_d = StGrant;
          idx_d   = pick_idx;
          tmo_d   = '0;
        end
      end
      StGrant: begin
        tmo_d = tmo_q + 10'd1;
        if (done_k || tmo_hit) begin
          served_d = served_q | idx_oh;
          terr_d   = terr_q | ~done_k;
          if (moves_ptr) ptr_d = ptr_inc(idx_q);
          state_d  = StArb;
        end else if (close && moves_ptr) begin
          // Aborted requester goes first next window.
          ptr_d = idx_q;
        end
        if (close) begin
          state_d = StDone;
          oerr_d  = oerr_q | (|(iReq & ~served_d));
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q     <= StIdle;
      open_q      <= 1'b0;
      ptr_q       <= '0;
      idx_q       <= '0;
      served_q    <= '0;
      tmo_q       <= '0;
      tick_q      <= 1'b0;
      terr_q      <= 1'b0;
      oerr_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      open_q      <= open_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      served_q    <= served_d;
      tmo_q       <= tmo_d;
      tick_q      <= tick_d;
      terr_q      <= terr_d;
      oerr_q      <= oerr_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign oGrant       = (state_q == StGrant) ? idx_oh : '0;
  assign oBusy        = (state_q == StArb) || (state_q == StGrant);
  assign oFrame_Tick  = tick_q;
  assign oServed      = served_q;
  assign oTimeout_Err = terr_q;
  assign oOverrun_Err = oerr_q;
  assign oFrame_Cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Bench for vblank_update_scheduler: windowed round-robin grants, timeout, overrun, reset.
module tb_vblank_update_scheduler;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    v, h;
  logic [N-1:0]  req, done;
  logic [N-1:0]  grant, served;
  logic          busy, tick, terr, oerr;
  logic [15:0]   fcnt;

  always #5 clk = ~clk;

  vblank_update_scheduler #(
    .NUM_REQ(N), .Y_START(34), .V_ACT(480), .GUARD_LINES(2), .TIMEOUT(1023)
  ) dut (
    .iCLK(clk), .iRST(rst), .iV_Cont(v), .iH_Cont(h), .iReq(req), .iDone(done),
    .oGrant(grant), .oBusy(busy), .oFrame_Tick(tick), .oServed(served),
    .oTimeout_Err(terr), .oOverrun_Err(oerr), .oFrame_Cnt(fcnt)
  );

  int checks = 0;
  int failures = 0;
  int dly[N];
  int gcnt[N];
  int exp_q[$];
  int hold_cnt = 0;
  int last_hold = 0;
  logic [N-1:0] prev_grant = '0;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] d;
    logic [2:0] n;
    logic [7:0] ord;
    logic [3:0] served;
  } win_t;
  win_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester model: pulse iDone after dly[k] grant cycles, never if dly[k]==0.
  initial begin
    done = '0;
    for (int k = 0; k < N; k++) gcnt[k] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        done[k] = 1'b0;
        if (grant[k]) begin
          gcnt[k]++;
          if (dly[k] != 0 && gcnt[k] == dly[k]) done[k] = 1'b1;
        end else begin
          gcnt[k] = 0;
        end
      end
    end
  end

  // Scoreboard: each new grant pops the next expected requester index.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (grant != '0 && prev_grant == '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 32'(grant), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("grant_order", 32'(grant), 32'd1 << e);
        end
        hold_cnt = 0;
      end
      if (grant != '0) hold_cnt++;
      else if (prev_grant != '0) last_hold = hold_cnt;
      prev_grant = grant;
    end
  end

  task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_tick"}, 32'(tick), 32'd0);
    chk({tag, "_served"}, 32'(served), 32'd0);
    chk({tag, "_terr"}, 32'(terr), 32'd0);
    chk({tag, "_oerr"}, 32'(oerr), 32'd0);
    chk({tag, "_fcnt"}, 32'(fcnt), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; v = 10'd0; h = 10'd1; req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Pulse the open strobe and check tick/busy/first-grant latency.
  task automatic open_frame(input int first);
    @(negedge clk);
    v = 10'd514; h = 10'd0;
    @(negedge clk);
    v = 10'd0; h = 10'd1;
    chk("tick_early", 32'(tick), 32'd0);
    @(negedge clk);
    chk("frame_tick", 32'(tick), 32'd1);
    chk("busy_open", 32'(busy), 32'd1);
    @(negedge clk);
    chk("tick_one_cycle", 32'(tick), 32'd0);
    if (first >= 0) chk("first_grant_latency", 32'(grant), 32'd1 << first);
  endtask

  task automatic close_window();
    @(negedge clk);
    v = 10'd32; h = 10'd0;
    @(negedge clk);
    v = 10'd0; h = 10'd1;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("window_done_in_budget", 32'(k < budget), 32'd1);
  endtask

  task automatic wait_grant(input logic [N-1:0] m, input int budget);
    int k = 0;
    while (grant !== m && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("grant_reached", 32'(k < budget), 32'd1);
  endtask

  initial begin
    tbl[0] = '{req: 4'b1011, d: 4'd5, n: 3'd3, ord: {2'd0, 2'd3, 2'd1, 2'd0}, served: 4'b1011};
    tbl[1] = '{req: 4'b0110, d: 4'd1, n: 3'd2, ord: {2'd0, 2'd0, 2'd2, 2'd1}, served: 4'b0110};
    tbl[2] = '{req: 4'b1111, d: 4'd3, n: 3'd4, ord: {2'd2, 2'd1, 2'd0, 2'd3}, served: 4'b1111};
    tbl[3] = '{req: 4'b0000, d: 4'd5, n: 3'd0, ord: 8'd0, served: 4'b0000};
    tbl[4] = '{req: 4'b0101, d: 4'd2, n: 3'd2, ord: {2'd0, 2'd0, 2'd2, 2'd0}, served: 4'b0101};

    rst = 1'b1; v = 10'd0; h = 10'd1; req = '0;
    set_dly(0, 0, 0, 0);
    do_reset();
    check_reset_vals("reset");

    // Round-robin windows; the pointer carries over between entries.
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < N; k++) dly[k] = int'(tbl[i].d);
      req = tbl[i].req;
      for (int j = 0; j < int'(tbl[i].n); j++) exp_q.push_back(int'(tbl[i].ord[2*j +: 2]));
      open_frame(tbl[i].n != 3'd0 ? int'(tbl[i].ord[1:0]) : -1);
      wait_idle(200);
      chk("served", 32'(served), 32'(tbl[i].served));
      chk("frame_cnt", 32'(fcnt), i + 1);
      chk("grants_left", exp_q.size(), 0);
      chk("grant_idle", 32'(grant), 32'd0);
    end
    chk("no_terr", 32'(terr), 32'd0);
    chk("no_oerr", 32'(oerr), 32'd0);

    // Timeout: requester 2 never completes.
    req = 4'b0100;
    set_dly(0, 0, 0, 0);
    exp_q.push_back(2);
    open_frame(2);
    wait_idle(1100);
    chk("timeout_hold", last_hold, 1023);
    chk("timeout_err", 32'(terr), 32'd1);
    chk("timeout_served", 32'(served), 32'b0100);
    set_dly(5, 5, 5, 5);
    exp_q.push_back(2);
    open_frame(2);
    wait_idle(200);
    chk("timeout_regrant_served", 32'(served), 32'b0100);
    chk("timeout_sticky", 32'(terr), 32'd1);
    chk("timeout_grants_left", exp_q.size(), 0);

    // Overrun: requester 1 still holds the grant at the close strobe.
    do_reset();
    req = 4'b0010;
    set_dly(0, 0, 0, 0);
    exp_q.push_back(1);
    open_frame(1);
    repeat (10) @(negedge clk);
    close_window();
    chk("close_grant_drop", 32'(grant), 32'd0);
    chk("close_busy", 32'(busy), 32'd0);
    chk("overrun_err", 32'(oerr), 32'd1);
    chk("overrun_no_terr", 32'(terr), 32'd0);
    chk("overrun_served", 32'(served), 32'd0);
    req = 4'b0011;
    set_dly(5, 5, 5, 5);
    exp_q.push_back(1);
    exp_q.push_back(0);
    open_frame(1);
    wait_idle(200);
    chk("overrun_next_served", 32'(served), 32'b0011);
    chk("overrun_sticky", 32'(oerr), 32'd1);

    // Pointer wrap: frame 1 aborts requester 2, frame 2 resumes there.
    do_reset();
    req = 4'b0111;
    set_dly(5, 5, 0, 5);
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    open_frame(0);
    wait_grant(4'b0100, 100);
    repeat (3) @(negedge clk);
    close_window();
    chk("wrap_grant_drop", 32'(grant), 32'd0);
    chk("wrap_overrun", 32'(oerr), 32'd1);
    chk("wrap_served1", 32'(served), 32'b0011);
    req = 4'b1111;
    set_dly(5, 5, 5, 5);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    exp_q.push_back(1);
    open_frame(2);
    wait_idle(200);
    chk("wrap_served2", 32'(served), 32'b1111);
    chk("wrap_grants_left", exp_q.size(), 0);
    chk("wrap_frame_cnt", 32'(fcnt), 32'd2);

    // Reset asserted while a grant is held.
    req = 4'b0001;
    set_dly(0, 0, 0, 0);
    exp_q.push_back(0);
    open_frame(0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midgrant_reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_idle_grant", 32'(grant), 32'd0);
    chk("post_reset_grants_left", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
